// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one start/done ALU among NUM_REQ requesters.
// Optional watchdog in WAIT is enabled by defining ALU_ARB_TIMEOUT_EN.
module alu_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*8-1:0] i_req_a,
  input  logic [NUM_REQ*8-1:0] i_req_b,
  input  logic [NUM_REQ*3-1:0] i_req_op,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  output logic [15:0]          o_rsp_result,
  output logic                 o_rsp_err,
  output logic                 o_busy,
  output logic [7:0]           o_alu_a,
  output logic [7:0]           o_alu_b,
  output logic [2:0]           o_alu_op,
  output logic                 o_alu_start,
  output logic                 o_alu_rst_n,
  input  logic                 i_alu_done,
  input  logic [15:0]          i_alu_result,
  output logic [2:0]           o_dbg_state
);

  // Handshakes: requester i holds i_req[i] (with stable operands) until the single-cycle
  // o_rsp_valid[i] pulse; the ALU sees o_alu_start held high until i_alu_done is sampled in WAIT.

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0] L_N    = (PW+1)'(NUM_REQ);
  localparam logic [2:0]  OP_NOP = 3'b000;
  localparam logic [2:0]  OP_RST = 3'b111;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ARST  = 3'd3,
    RESP  = 3'd4
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("alu_share_arbiter: parameter out of range");
  end

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_gnt;
  logic [7:0]           r_alu_a;
  logic [7:0]           r_alu_b;
  logic [2:0]           r_alu_op;
  logic                 r_alu_start;
  logic                 r_alu_rst_n;
  logic                 r_arst_cnt;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [15:0]          r_rsp_result;
  logic                 r_rsp_err;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] L_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]        r_tcnt;
  logic                 r_timeout;
`endif

  logic                 w_hit_hi;
  logic                 w_hit_lo;
  logic [PW-1:0]        w_gnt_hi;
  logic [PW-1:0]        w_gnt_lo;
  logic                 w_hit;
  logic [PW-1:0]        w_gnt;
  logic [PW:0]          w_gnt_inc;
  logic [PW-1:0]        w_ptr_nxt;
  logic [7:0]           w_sel_a;
  logic [7:0]           w_sel_b;
  logic [2:0]           w_sel_op;
  logic [NUM_REQ-1:0]   w_gnt_oh;

  // Two-pass priority: lowest requester at/after r_ptr first, then wrap to the lowest below it.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_gnt_hi = '0;
    w_gnt_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        if (i[PW-1:0] >= r_ptr) begin
          w_hit_hi = 1'b1;
          w_gnt_hi = i[PW-1:0];
        end else begin
          w_hit_lo = 1'b1;
          w_gnt_lo = i[PW-1:0];
        end
      end
    end
  end

  assign w_hit     = w_hit_hi | w_hit_lo;
  assign w_gnt     = w_hit_hi ? w_gnt_hi : w_gnt_lo;
  assign w_gnt_inc = {1'b0, w_gnt} + 1'b1;
  assign w_ptr_nxt = (w_gnt_inc == L_N) ? '0 : w_gnt_inc[PW-1:0];
  assign w_gnt_oh  = NUM_REQ'(1) << r_gnt;

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt == i[PW-1:0]) begin
        w_sel_a  = i_req_a[i*8 +: 8];
        w_sel_b  = i_req_b[i*8 +: 8];
        w_sel_op = i_req_op[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_gnt        <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_op     <= '0;
      r_alu_start  <= 1'b0;
      r_alu_rst_n  <= 1'b0;
      r_arst_cnt   <= 1'b0;
      r_rsp_valid  <= '0;
      r_rsp_result <= '0;
      r_rsp_err    <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      r_tcnt       <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_alu_rst_n <= 1'b1;
          if (w_hit) begin
            r_gnt    <= w_gnt;
            r_ptr    <= w_ptr_nxt;
            r_alu_a  <= w_sel_a;
            r_alu_b  <= w_sel_b;
            r_alu_op <= w_sel_op;
            if (w_sel_op == OP_RST) begin
              r_state     <= ARST;
              r_alu_rst_n <= 1'b0;
              r_arst_cnt  <= 1'b0;
            end else begin
              r_state     <= ISSUE;
              r_alu_start <= 1'b1;
            end
          end
        end

        // no_op never produces done, so it completes straight from the start cycle.
        ISSUE: begin
          if (r_alu_op == OP_NOP) begin
            r_alu_start  <= 1'b0;
            r_state      <= RESP;
            r_rsp_valid  <= w_gnt_oh;
            r_rsp_result <= '0;
          end else begin
            r_state <= WAIT;
`ifdef ALU_ARB_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
          end
        end

        WAIT: begin
          if (i_alu_done) begin
            r_alu_start  <= 1'b0;
            r_state      <= RESP;
            r_rsp_valid  <= w_gnt_oh;
            r_rsp_result <= i_alu_result;
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (r_tcnt == L_TO_LAST) begin
            r_alu_start <= 1'b0;
            r_alu_rst_n <= 1'b0;
            r_arst_cnt  <= 1'b0;
            r_timeout   <= 1'b1;
            r_state     <= ARST;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
`endif
        end

        ARST: begin
          if (r_arst_cnt) begin
            r_alu_rst_n  <= 1'b1;
            r_state      <= RESP;
            r_rsp_valid  <= w_gnt_oh;
            r_rsp_result <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            r_rsp_err    <= r_timeout;
`endif
          end else begin
            r_arst_cnt <= 1'b1;
          end
        end

        RESP: begin
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_state     <= IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
          r_timeout   <= 1'b0;
`endif
        end

        default: begin
          r_alu_start <= 1'b0;
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_err    = r_rsp_err;
  assign o_busy       = (r_state != IDLE);
  assign o_alu_a      = r_alu_a;
  assign o_alu_b      = r_alu_b;
  assign o_alu_op     = r_alu_op;
  assign o_alu_start  = r_alu_start;
  assign o_alu_rst_n  = r_alu_rst_n;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one start/done-handshake ALU (8-bit A/B, 3-bit op, 16-bit result) among NUM_REQ requesters. It sits between the requesting agents and the ALU. It owns the ALU's start, operand, op and reset pins. It returns each result to the requester that issued the operation.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- TIMEOUT_CYCLES, 16: watchdog limit in WAIT; used only with ALU_ARB_TIMEOUT_EN.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held until that requester's rsp_valid.
- req_a  in  NUM_REQ*8  operand A, slice i for requester i.
- req_b  in  NUM_REQ*8  operand B.
- req_op  in  NUM_REQ*3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 111 rst_op.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the served requester.
- rsp_result  out  16  result; valid while any rsp_valid bit is high.
- rsp_err  out  1  timeout flag qualified by rsp_valid; tied 0 without the macro.
- busy  out  1  high whenever state != IDLE.
- alu_a, alu_b  out  8  registered operands to the ALU.
- alu_op  out  3  registered opcode.
- alu_start  out  1  ALU start.
- alu_rst_n  out  1  ALU reset, active-low.
- alu_done  in  1  ALU done.
- alu_result  in  16  ALU result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ARST, RESP.
- **IDLE**
  - Search req round-robin, starting at ptr. ptr resets to 0.
  - On a hit g: latch its A, B and op into alu_a, alu_b and alu_op. Set ptr = (g+1) mod NUM_REQ.
  - Next state: ARST if op = 111, else ISSUE.
- **ISSUE**
  - alu_start = 1.
  - op = 000: the ALU never raises done for no_op. Next state is RESP with result 0.
  - Any other op: next state is WAIT.
- **WAIT**
  - alu_start stays 1.
  - When alu_done is sampled 1: capture alu_result, drop alu_start, go to RESP.
  - Undefined ops (101, 110) are forwarded unchanged and wait for done.
- **ARST**
  - Two cycles with alu_rst_n = 0 and alu_start = 0, then RESP with result 0.
- **RESP**
  - rsp_valid[g] = 1 and rsp_result = the captured value for one cycle. alu_start = 0.
  - Next state is IDLE. This guarantees alu_start is low for at least one cycle between operations.
- A granted transaction is committed. If req[g] drops mid-service, the response still fires.
- Requests that arrive during service wait for IDLE. Nothing is lost and there is no queueing beyond the held req.
- Requester identity is tracked internally as a grant index. The result is not modified; width is 16 for every op.

## Timing
- Reset values:
  - alu_a, alu_b = 0; alu_op = 000; alu_start = 0; alu_rst_n = 0 while rst, 1 the cycle after rst deasserts.
  - rsp_valid = 0; rsp_result = 0; rsp_err = 0; busy = 0; state = IDLE; ptr = 0.
- Cycle counts, with req sampled in IDLE at cycle T:
  - alu_start rises at T+1.
  - For ALU ops, done is sampled at cycle D ≥ T+2 and rsp_valid fires at D+1.
  - no_op: rsp_valid at T+2.
  - rst_op: alu_rst_n is low at T+1 and T+2; rsp_valid at T+3.
  - The earliest next grant is sampled the cycle after rsp_valid.
- Reset mid-operation: rst on any cycle forces the reset values next edge and abandons the transaction. No rsp_valid is issued for it.
- Simultaneous requests: the lowest index at or after ptr (wrapping) wins. ptr wrap from NUM_REQ-1 goes to 0.
- alu_done is ignored outside WAIT.

## Configuration
- ALU_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without done: drop alu_start, enter ARST (two-cycle ALU reset), then RESP with rsp_result = 0 and rsp_err = 1.
- Not defined:
  - The counter is absent and rsp_err is tied 0.
  - WAIT persists until alu_done or rst.

## Test plan
- Single add: req0 with A=8'h12, B=8'h34, op=001; ALU done 1 cycle after start -> rsp_valid[0] one pulse, rsp_result 16'h0046, busy low the next cycle.
- Contention: req=4'b1111, all op=011 with distinct operands, held -> grant order 0,1,2,3,0. Each rsp_valid is a single pulse, and alu_start is low ≥1 cycle between operations.
- Multi-cycle mul: A=8'hFF, B=8'hFF, op=100; done after 3 cycles -> alu_start held high throughout WAIT, rsp_result 16'hFE01.
- no_op and rst_op: req1 op=000 -> rsp_valid[1] at T+2, result 0, alu_start high exactly 1 cycle. req2 op=111 -> alu_rst_n low exactly 2 cycles, rsp_valid[2] at T+3.
- Reset mid-WAIT: assert rst during a mul -> next cycle alu_start=0, alu_rst_n=0, no rsp_valid, ptr=0. A subsequent req3 is served normally.
- Timeout, with macro: alu_done held 0 -> after 16 WAIT cycles alu_rst_n pulses low 2 cycles, then rsp_valid with rsp_err=1 and result 0. Without macro: busy stays 1 indefinitely.
